// File: rtl/gradient_window_ctrl.sv
// Sobel window sequencer: tracks pixel column/row and qualifies fully-inside KxK windows.
// Latency: shift/address combinational with the accepted pixel; qualifiers, rotate and error one cycle later.
// Backpressure: none; gaps in i_pixel_valid stall the counters and the registered qualifiers drop to 0.
module gradient_window_ctrl #(
    parameter int KERNEL_SIZE  = 5,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_reset,
    input  logic                                                 i_pixel_valid,
    input  logic                                                 i_start_of_frame,
    output logic                                                 o_shift_en,
    output logic [((IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1)-1:0] o_lb_wr_addr,
    output logic                                                 o_lb_rotate,
    output logic                                                 o_kernel_valid,
    output logic                                                 o_kernel_sof,
    output logic                                                 o_kernel_eof,
    output logic [((IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1)-1:0] o_col,
    output logic [((IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1)-1:0] o_row,
    output logic                                                 o_frame_error,
    output logic                                                 o_busy
);

    localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] COL_K    = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, pix_col;
    logic [RW-1:0] row_q, row_d, pix_row;
    logic          accept, restart, last_col, last_row;
    logic          rotate_q, kvalid_q, ksof_q, keof_q, error_q, busy_q;

    always_comb begin
        restart  = i_pixel_valid & i_start_of_frame;
        accept   = i_pixel_valid & ((state_q != IDLE) | i_start_of_frame);
        // A sof pixel is always position (0,0), even when it aborts a frame mid-way.
        pix_col  = restart ? '0 : col_q;
        pix_row  = restart ? '0 : row_q;
        last_col = (pix_col == COL_LAST);
        last_row = (pix_row == ROW_LAST);
        col_d    = col_q;
        row_d    = row_q;
        state_d  = state_q;
        if (accept) begin
            col_d = last_col ? '0 : pix_col + COL_ONE;
            row_d = last_col ? (last_row ? '0 : pix_row + ROW_ONE) : pix_row;
            if (last_col && last_row) begin
                state_d = IDLE;
            end else if (row_d >= ROW_K) begin
                state_d = ACTIVE;
            end else begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            rotate_q <= 1'b0;
            kvalid_q <= 1'b0;
            ksof_q   <= 1'b0;
            keof_q   <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            rotate_q <= accept & last_col;
            kvalid_q <= accept & (pix_row >= ROW_K) & (pix_col >= COL_K);
            ksof_q   <= accept & (pix_row == ROW_K) & (pix_col == COL_K);
            keof_q   <= accept & last_row & last_col;
            error_q  <= restart & (state_q != IDLE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign o_shift_en     = accept;
    assign o_lb_wr_addr   = pix_col;
    assign o_lb_rotate    = rotate_q;
    assign o_kernel_valid = kvalid_q;
    assign o_kernel_sof   = ksof_q;
    assign o_kernel_eof   = keof_q;
    assign o_col          = col_q;
    assign o_row          = row_q;
    assign o_frame_error  = error_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_gradient_window_ctrl.sv
// Bench for gradient_window_ctrl at default parameters (K=5, 10x10 frame).
module tb_gradient_window_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_pixel_valid = 1'b0;
    logic       i_start_of_frame = 1'b0;
    logic       o_shift_en, o_lb_rotate, o_kernel_valid, o_kernel_sof, o_kernel_eof;
    logic       o_frame_error, o_busy;
    logic [3:0] o_lb_wr_addr, o_col, o_row;

    gradient_window_ctrl #(
        .KERNEL_SIZE(5), .IMAGE_WIDTH(10), .IMAGE_HEIGHT(10)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pixel_valid(i_pixel_valid),
        .i_start_of_frame(i_start_of_frame), .o_shift_en(o_shift_en),
        .o_lb_wr_addr(o_lb_wr_addr), .o_lb_rotate(o_lb_rotate),
        .o_kernel_valid(o_kernel_valid), .o_kernel_sof(o_kernel_sof),
        .o_kernel_eof(o_kernel_eof), .o_col(o_col), .o_row(o_row),
        .o_frame_error(o_frame_error), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit v, s, r;
        int shift, addr, kv, rot, err, busy, col, row;
    } vec_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    // Samples of the most recent step and per-sequence tallies.
    int s_shift, s_addr, s_kv, s_ksof, s_keof, s_rot, s_err, s_busy, s_col, s_row;
    int n_shift, n_kv, n_ksof, n_keof, n_rot, n_err, pix_idx;
    int first_kv, first_sof, last_kv, last_eof, gap_bad;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_shift = 0; n_kv = 0; n_ksof = 0; n_keof = 0; n_rot = 0; n_err = 0;
        pix_idx = 0; first_kv = -1; first_sof = 0; last_kv = -1; last_eof = 0; gap_bad = 0;
    endtask

    task automatic step(input bit v, input bit s, input bit r);
        i_pixel_valid = v; i_start_of_frame = s; i_reset = r;
        #1;
        s_shift = int'(o_shift_en); s_addr = int'(o_lb_wr_addr);
        @(posedge i_clk);
        #1;
        s_kv = int'(o_kernel_valid); s_ksof = int'(o_kernel_sof); s_keof = int'(o_kernel_eof);
        s_rot = int'(o_lb_rotate); s_err = int'(o_frame_error); s_busy = int'(o_busy);
        s_col = int'(o_col); s_row = int'(o_row);
        n_shift += s_shift; n_ksof += s_ksof; n_keof += s_keof; n_rot += s_rot; n_err += s_err;
        if (s_kv != 0) begin
            if (n_kv == 0) begin
                first_kv = pix_idx; first_sof = s_ksof;
            end
            last_kv = pix_idx; last_eof = s_keof;
            n_kv++;
        end
        if (v) pix_idx++;
    endtask

    // 100-pixel frame with sof on the first; optional idle cycle after every pixel.
    task automatic send_frame(input bit gaps, input bit check_kv);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, i == 0, 1'b0);
            if (check_kv) chk("kv_px", s_kv, ((i / 10) >= 4 && (i % 10) >= 4) ? 1 : 0);
            if (gaps) begin
                step(1'b0, 1'b0, 1'b0);
                if (s_shift != 0 || s_kv != 0) gap_bad++;
            end
        end
    endtask

    initial begin
        //            v  s  r  shift addr kv rot err busy col row
        vecs[0] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 0, 1, 1, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1, 2, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 0, 2, 0, 0, 0, 1, 2, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 1, 1, 1, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1, 2, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 0, 2, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};

        clear_counts();
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].v, vecs[i].s, vecs[i].r);
            chk($sformatf("vec%0d_shift", i), s_shift, vecs[i].shift);
            chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].addr);
            chk($sformatf("vec%0d_kv", i), s_kv, vecs[i].kv);
            chk($sformatf("vec%0d_rot", i), s_rot, vecs[i].rot);
            chk($sformatf("vec%0d_err", i), s_err, vecs[i].err);
            chk($sformatf("vec%0d_busy", i), s_busy, vecs[i].busy);
            chk($sformatf("vec%0d_col", i), s_col, vecs[i].col);
            chk($sformatf("vec%0d_row", i), s_row, vecs[i].row);
        end

        // Continuous full frame.
        clear_counts();
        send_frame(1'b0, 1'b1);
        chk("full_kv_count", n_kv, 36);
        chk("full_first_kv_px", first_kv, 44);
        chk("full_first_sof", first_sof, 1);
        chk("full_last_kv_px", last_kv, 99);
        chk("full_last_eof", last_eof, 1);
        chk("full_ksof_count", n_ksof, 1);
        chk("full_keof_count", n_keof, 1);
        chk("full_rot_count", n_rot, 10);
        chk("full_err_count", n_err, 0);
        chk("full_busy_after", s_busy, 0);

        // Same frame with a gap after every pixel.
        clear_counts();
        send_frame(1'b1, 1'b0);
        chk("gap_kv_count", n_kv, 36);
        chk("gap_first_kv_px", first_kv, 44);
        chk("gap_first_sof", first_sof, 1);
        chk("gap_last_kv_px", last_kv, 99);
        chk("gap_last_eof", last_eof, 1);
        chk("gap_rot_count", n_rot, 10);
        chk("gap_cycle_violations", gap_bad, 0);

        // Valid without sof while idle is dropped.
        clear_counts();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("nosof_shift_count", n_shift, 0);
        chk("nosof_err_count", n_err, 0);
        chk("nosof_col", s_col, 0);
        chk("nosof_row", s_row, 0);
        chk("nosof_busy", s_busy, 0);
        clear_counts();
        send_frame(1'b0, 1'b0);
        chk("after_nosof_kv_count", n_kv, 36);

        // Mid-frame sof on pixel 50.
        clear_counts();
        for (int i = 0; i < 50; i++) step(1'b1, i == 0, 1'b0);
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        chk("midsof_err", s_err, 1);
        chk("midsof_col", s_col, 1);
        chk("midsof_row", s_row, 0);
        chk("midsof_addr", s_addr, 0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
        chk("midsof_kv_count", n_kv, 36);
        chk("midsof_err_count", n_err, 1);
        chk("midsof_keof_count", n_keof, 1);
        chk("midsof_ksof_count", n_ksof, 1);
        chk("midsof_busy_after", s_busy, 0);

        // Reset in the middle of a frame at pixel 60.
        clear_counts();
        for (int i = 0; i < 60; i++) step(1'b1, i == 0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_kv", s_kv, 0);
        chk("rst_ksof", s_ksof, 0);
        chk("rst_keof", s_keof, 0);
        chk("rst_rot", s_rot, 0);
        chk("rst_err", s_err, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_col", s_col, 0);
        chk("rst_row", s_row, 0);
        clear_counts();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        chk("rst_drop_shift", n_shift, 0);
        chk("rst_drop_kv", n_kv, 0);

        // Two frames back to back.
        clear_counts();
        for (int i = 0; i < 200; i++) step(1'b1, (i % 100) == 0, 1'b0);
        chk("b2b_kv_count", n_kv, 72);
        chk("b2b_ksof_count", n_ksof, 2);
        chk("b2b_keof_count", n_keof, 2);
        chk("b2b_err_count", n_err, 0);
        chk("b2b_rot_count", n_rot, 20);
        chk("b2b_busy_after", s_busy, 0);

        i_pixel_valid = 1'b0;
        i_start_of_frame = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
